// File: rtl/mic_capture_ctrl_if.sv
// Sample stream from the I2S capture controller to the downstream audio logic.
// The master presents a sample with valid and the slave accepts it with ready.
interface mic_capture_ctrl_if #(
    parameter int DATA_BITS = 18
);
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/mic_capture_ctrl.sv
// I2S PCM microphone capture sequencer: generates BCLK/WS, shifts in the left-slot
// sample and hands it downstream over valid/ready, flagging samples lost to backpressure.
module mic_capture_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 18,
    parameter int SLOT_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mic_data,
    output logic                     bclk,
    output logic                     ws,
    output logic                     overrun,
    output logic                     busy,
    mic_capture_ctrl_if.master       smp
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SLOT_BITS);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t               state;
    logic [DIV_W-1:0]     div;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    logic                 tick;
    logic                 rise;
    logic                 fall;
    logic                 frame_end;
    logic                 shift_en;
    logic                 complete;
    logic [DATA_BITS-1:0] next_shift;

    // Bit 0 of the left slot is the I2S one-bit delay, so data lives in bits 1..DATA_BITS.
    always_comb begin
        tick       = (state != IDLE) && (div == DIV_W'(CLK_DIV - 1));
        rise       = tick && !bclk;
        fall       = tick && bclk;
        frame_end  = fall && ws && (bit_cnt == CNT_W'(SLOT_BITS - 1));
        shift_en   = rise && !ws && (bit_cnt >= CNT_W'(1)) && (bit_cnt <= CNT_W'(DATA_BITS));
        complete   = shift_en && (bit_cnt == CNT_W'(DATA_BITS));
        next_shift = {shift[DATA_BITS-2:0], mic_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            div              <= '0;
            bclk             <= 1'b0;
            ws               <= 1'b0;
            bit_cnt          <= '0;
            shift            <= '0;
            overrun          <= 1'b0;
            smp.sample       <= '0;
            smp.sample_valid <= 1'b0;
        end else begin
            // A completion on a transfer cycle replaces the outgoing sample, so valid stays high.
            if (complete) begin
                if (!smp.sample_valid || smp.sample_ready) begin
                    smp.sample       <= next_shift;
                    smp.sample_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (smp.sample_valid && smp.sample_ready) begin
                smp.sample_valid <= 1'b0;
            end

            if (shift_en) begin
                shift <= next_shift;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        overrun <= 1'b0;
                    end
                end
                default: begin
                    div <= tick ? '0 : div + 1'b1;
                    if (tick) begin
                        bclk <= !bclk;
                    end
                    if (fall) begin
                        if (bit_cnt == CNT_W'(SLOT_BITS - 1)) begin
                            bit_cnt <= '0;
                            ws      <= !ws;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // A stop landing exactly on a frame boundary ends capture on that edge.
                    if (frame_end && (state == STOPPING || stop)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        div     <= '0;
                        bclk    <= 1'b0;
                        ws      <= 1'b0;
                        bit_cnt <= '0;
                    end else if (state == RUN && stop) begin
                        state <= STOPPING;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Self-checking bench for mic_capture_ctrl: an I2S microphone model feeds words,
// a scoreboard checks every delivered sample, and timed checks cover clocking and corners.
module tb_mic_capture_ctrl;

    localparam int DATA_BITS = 18;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic start    = 1'b0;
    logic stop     = 1'b0;
    logic mic_data = 1'b0;
    logic bclk;
    logic ws;
    logic overrun;
    logic busy;

    mic_capture_ctrl_if #(.DATA_BITS(DATA_BITS)) smp ();

    mic_capture_ctrl #(
        .CLK_DIV  (4),
        .DATA_BITS(DATA_BITS),
        .SLOT_BITS(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mic_data(mic_data),
        .bclk    (bclk),
        .ws      (ws),
        .overrun (overrun),
        .busy    (busy),
        .smp     (smp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int e0         = 0;

    logic [DATA_BITS-1:0] mic_q[$];
    logic [DATA_BITS-1:0] exp_q[$];

    typedef struct {
        logic [DATA_BITS-1:0] word;
        logic                 ready;
        logic [DATA_BITS-1:0] exp_sample;
        logic                 exp_overrun;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc - e0);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_BITS-1:0] word, input bit deliver);
        mic_q.push_back(word);
        if (deliver) exp_q.push_back(word);
    endtask

    // Advance to 1ns after edge e0+n.
    task automatic at_edge(input int n);
        while (cyc < e0 + n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_capture();
        start = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        checkOutput("busy_at_E0", 32'(busy), 1);
    endtask

    task automatic stop_pulse();
        int now_rel;
        now_rel = cyc - e0;
        stop = 1'b1;
        at_edge(now_rel + 1);
        stop = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_bclk"},    32'(bclk), 0);
        checkOutput({tag, "_ws"},      32'(ws), 0);
        checkOutput({tag, "_sample"},  32'(smp.sample), 0);
        checkOutput({tag, "_valid"},   32'(smp.sample_valid), 0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 0);
        checkOutput({tag, "_busy"},    32'(busy), 0);
    endtask

    // Microphone model: drives a new bit after each BCLK falling edge, MSB one bit after WS.
    int                   fcount = 0;
    int                   pos;
    logic                 prev_bclk = 1'b0;
    logic [DATA_BITS-1:0] cur_word = '0;
    always @(negedge clk) begin
        if (!busy) begin
            fcount    = 0;
            prev_bclk = 1'b0;
        end else begin
            if (prev_bclk && !bclk) begin
                fcount++;
                pos = fcount % 64;
                if (pos == 1) begin
                    if (mic_q.size() > 0) cur_word = mic_q.pop_front();
                    else                  cur_word = DATA_BITS'($urandom);
                end
                if (pos >= 1 && pos <= DATA_BITS) mic_data = cur_word[DATA_BITS-pos];
                else                              mic_data = 1'($urandom);
            end
            prev_bclk = bclk;
        end
    end

    // Scoreboard: every valid&ready transfer must match the next expected sample.
    always @(negedge clk) begin
        if (!rst && smp.sample_valid && smp.sample_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_transfer: got %0h, expected no transfer", smp.sample);
            end else begin
                logic [DATA_BITS-1:0] e;
                e = exp_q.pop_front();
                if (smp.sample !== e) begin
                    mismatched++;
                    $display("[TB] FAIL transfer_sample: got %0h, expected %0h", smp.sample, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{18'h2A5A5, 1'b1, 18'h2A5A5, 1'b0};
        vecs[1] = '{18'h3FFFF, 1'b1, 18'h3FFFF, 1'b0};
        vecs[2] = '{18'h00000, 1'b1, 18'h00000, 1'b0};
        vecs[3] = '{18'h20000, 1'b1, 18'h20000, 1'b0};
        vecs[4] = '{18'h1FFFF, 1'b1, 18'h1FFFF, 1'b0};
        vecs[5] = '{18'h00001, 1'b1, 18'h00001, 1'b0};

        smp.sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_busy", 32'(busy), 0);

        $display("[TB] continuous capture with clocking checks");
        foreach (vecs[i]) applyStimulus(vecs[i].word, 1'b1);
        smp.sample_ready = 1'b1;
        start_capture();
        at_edge(3);  checkOutput("bclk_e3", 32'(bclk), 0);
        at_edge(4);  checkOutput("bclk_e4", 32'(bclk), 1);
        at_edge(7);  checkOutput("bclk_e7", 32'(bclk), 1);
        at_edge(8);  checkOutput("bclk_e8", 32'(bclk), 0);
        at_edge(12); checkOutput("bclk_e12", 32'(bclk), 1);
        for (int i = 0; i < 6; i++) begin
            int base;
            base = 512 * i;
            at_edge(base + 147);
            smp.sample_ready = vecs[i].ready;
            checkOutput("valid_before", 32'(smp.sample_valid), 0);
            at_edge(base + 148);
            checkOutput("valid_at_completion", 32'(smp.sample_valid), 1);
            checkOutput("sample_at_completion", 32'(smp.sample), 32'(vecs[i].exp_sample));
            checkOutput("overrun_at_completion", 32'(overrun), 32'(vecs[i].exp_overrun));
            at_edge(base + 149);
            checkOutput("valid_after", 32'(smp.sample_valid), 0);
            if (i == 0) begin
                at_edge(255); checkOutput("ws_e255", 32'(ws), 0);
                at_edge(256); checkOutput("ws_e256", 32'(ws), 1);
                at_edge(511); checkOutput("ws_e511", 32'(ws), 1);
                at_edge(512); checkOutput("ws_e512", 32'(ws), 0);
            end
        end
        stop_pulse();
        at_edge(3071); checkOutput("busy_before_end", 32'(busy), 1);
        at_edge(3072);
        checkOutput("busy_after_end", 32'(busy), 0);
        checkOutput("bclk_after_end", 32'(bclk), 0);
        checkOutput("ws_after_end", 32'(ws), 0);

        $display("[TB] backpressure and overrun");
        at_edge(3100);
        smp.sample_ready = 1'b0;
        applyStimulus(18'h2A5A5, 1'b1);
        applyStimulus(18'h15A5A, 1'b0);
        start_capture();
        at_edge(148);
        checkOutput("bp_valid", 32'(smp.sample_valid), 1);
        checkOutput("bp_sample", 32'(smp.sample), 32'(18'h2A5A5));
        at_edge(659); checkOutput("bp_overrun_before", 32'(overrun), 0);
        at_edge(660);
        checkOutput("bp_overrun", 32'(overrun), 1);
        checkOutput("bp_sample_held", 32'(smp.sample), 32'(18'h2A5A5));
        checkOutput("bp_valid_held", 32'(smp.sample_valid), 1);
        at_edge(700);
        smp.sample_ready = 1'b1;
        at_edge(701);
        checkOutput("bp_valid_drop", 32'(smp.sample_valid), 0);
        stop_pulse();
        at_edge(1024);
        checkOutput("bp_busy_idle", 32'(busy), 0);
        checkOutput("bp_overrun_sticky", 32'(overrun), 1);
        at_edge(1030);
        applyStimulus(18'h0F0F0, 1'b1);
        start_capture();
        checkOutput("bp_overrun_cleared", 32'(overrun), 0);
        at_edge(148);
        checkOutput("bp_restart_sample", 32'(smp.sample), 32'(18'h0F0F0));
        stop_pulse();
        at_edge(512);
        checkOutput("bp_restart_idle", 32'(busy), 0);

        $display("[TB] completion coincident with handshake");
        at_edge(520);
        smp.sample_ready = 1'b0;
        applyStimulus(18'h12345, 1'b1);
        applyStimulus(18'h3C3C3, 1'b1);
        start_capture();
        at_edge(148);
        checkOutput("sim_first_sample", 32'(smp.sample), 32'(18'h12345));
        at_edge(659);
        smp.sample_ready = 1'b1;
        at_edge(660);
        smp.sample_ready = 1'b0;
        checkOutput("sim_valid", 32'(smp.sample_valid), 1);
        checkOutput("sim_sample", 32'(smp.sample), 32'(18'h3C3C3));
        checkOutput("sim_overrun", 32'(overrun), 0);
        at_edge(670);
        smp.sample_ready = 1'b1;
        at_edge(671);
        checkOutput("sim_valid_drop", 32'(smp.sample_valid), 0);
        stop_pulse();
        at_edge(1024);
        checkOutput("sim_idle", 32'(busy), 0);

        $display("[TB] stop mid-frame");
        at_edge(1030);
        applyStimulus(18'h0BEEF, 1'b1);
        start_capture();
        at_edge(148);
        checkOutput("stop_sample", 32'(smp.sample), 32'(18'h0BEEF));
        at_edge(299);
        stop_pulse();
        at_edge(511); checkOutput("stop_busy_511", 32'(busy), 1);
        at_edge(512);
        checkOutput("stop_busy_512", 32'(busy), 0);
        checkOutput("stop_bclk_512", 32'(bclk), 0);
        at_edge(700);
        checkOutput("stop_no_second", 32'(smp.sample_valid), 0);

        $display("[TB] asynchronous reset mid-frame");
        at_edge(710);
        applyStimulus(18'h2AAAA, 1'b0);
        start_capture();
        at_edge(100);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        at_edge(103);
        check_idle_outputs("abort_hold");
        rst = 1'b0;
        at_edge(110);
        checkOutput("abort_no_valid", 32'(smp.sample_valid), 0);
        applyStimulus(18'h1C0DE, 1'b1);
        start_capture();
        at_edge(147); checkOutput("restart_valid_before", 32'(smp.sample_valid), 0);
        at_edge(148);
        checkOutput("restart_valid", 32'(smp.sample_valid), 1);
        checkOutput("restart_sample", 32'(smp.sample), 32'(18'h1C0DE));
        stop_pulse();
        at_edge(512);
        checkOutput("restart_idle", 32'(busy), 0);

        at_edge(520);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
